// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: issues instruction-bus requests for the current PC,
// captures responses into a registered decode slot with a one-entry skid, and drops stale responses after a redirect.
module ifetch_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc,
    output logic [1:0]  PCWrite,
    input  logic        flush,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        inst_misalign,
    input  logic        dec_ready
);

    localparam logic [1:0] PCW_LOAD = 2'b00;
    localparam logic [1:0] PCW_HOLD = 2'b01;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state, state_nxt;

    logic        skid_vld_p1;
    logic [31:0] skid_inst_p1;
    logic [63:0] skid_pc_p1;
    logic        skid_mis_p1;
    logic [63:0] req_addr_p1;

    logic        slot_free;
    logic        misalign;
    logic        slot_we;
    logic [31:0] slot_inst_d;
    logic        slot_mis_d;
    logic        skid_we;
    logic        skid_to_slot;
    logic        req_latch;

    always_comb begin
        slot_free    = !inst_valid || dec_ready;
        misalign     = (pc[1:0] != 2'b00);
        state_nxt    = state;
        PCWrite      = PCW_HOLD;
        ireq_valid   = 1'b0;
        ireq_addr    = req_addr_p1;
        slot_we      = 1'b0;
        slot_inst_d  = iresp_data;
        slot_mis_d   = 1'b0;
        skid_we      = 1'b0;
        skid_to_slot = 1'b0;
        req_latch    = 1'b0;

        case (state)
            FETCH: begin
                if (misalign) begin
                    // No bus traffic for a misaligned PC; the exception rides the slot instead.
                    if (slot_free) begin
                        slot_we     = 1'b1;
                        slot_inst_d = 32'h0;
                        slot_mis_d  = 1'b1;
                        PCWrite     = PCW_LOAD;
                    end
                end else begin
                    ireq_valid = 1'b1;
                    ireq_addr  = pc;
                    req_latch  = 1'b1;
                    if (iresp_data_ok) begin
                        PCWrite = PCW_LOAD;
                        if (slot_free) begin
                            slot_we = 1'b1;
                        end else begin
                            skid_we   = 1'b1;
                            state_nxt = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (dec_ready) begin
                    skid_to_slot = 1'b1;
                    state_nxt    = FETCH;
                end
            end
            DISCARD: begin
                ireq_valid = 1'b1;
                ireq_addr  = req_addr_p1;
                if (iresp_data_ok) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase

        // A redirect wins: kill buffered work and remember an outstanding request so its response is dropped.
        if (flush) begin
            PCWrite      = PCW_LOAD;
            slot_we      = 1'b0;
            skid_we      = 1'b0;
            skid_to_slot = 1'b0;
            state_nxt    = (ireq_valid && !iresp_data_ok) ? DISCARD : FETCH;
        end

        if (!reset) begin
            ireq_valid = 1'b0;
            PCWrite    = PCW_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= FETCH;
            inst_valid    <= 1'b0;
            inst          <= 32'h0;
            inst_pc       <= 64'h0;
            inst_misalign <= 1'b0;
            skid_vld_p1   <= 1'b0;
            skid_inst_p1  <= 32'h0;
            skid_pc_p1    <= 64'h0;
            skid_mis_p1   <= 1'b0;
            req_addr_p1   <= 64'h0;
        end else begin
            state <= state_nxt;
            if (req_latch) begin
                req_addr_p1 <= pc;
            end

            if (flush) begin
                inst_valid  <= 1'b0;
                skid_vld_p1 <= 1'b0;
            end else if (slot_we) begin
                inst_valid    <= 1'b1;
                inst          <= slot_inst_d;
                inst_pc       <= pc;
                inst_misalign <= slot_mis_d;
            end else if (skid_to_slot) begin
                inst_valid    <= skid_vld_p1;
                inst          <= skid_inst_p1;
                inst_pc       <= skid_pc_p1;
                inst_misalign <= skid_mis_p1;
                skid_vld_p1   <= 1'b0;
            end else if (inst_valid && dec_ready) begin
                inst_valid <= 1'b0;
            end

            if (skid_we) begin
                skid_vld_p1  <= 1'b1;
                skid_inst_p1 <= iresp_data;
                skid_pc_p1   <= pc;
                skid_mis_p1  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed-vector bench for ifetch_ctrl: each record drives one cycle, checks the
// combinational bus/PCWrite outputs before the edge and the registered slot after it.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc;
    logic [1:0]  PCWrite;
    logic        flush;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_misalign;
    logic        dec_ready;

    int n_total = 0;
    int n_pass  = 0;

    ifetch_ctrl dut (
        .clk(clk), .reset(reset), .pc(pc), .PCWrite(PCWrite), .flush(flush),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_misalign(inst_misalign), .dec_ready(dec_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [63:0] pc;
        logic        fl;
        logic        ok;
        logic [31:0] data;
        logic        rdy;
        logic [1:0]  pcw;
        logic        rv;
        logic [63:0] addr;
        logic        iv;
        logic [31:0] ins;
        logic [63:0] ipc;
        logic        mis;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic rst, input logic [63:0] p, input logic fl,
                                input logic ok, input logic [31:0] d, input logic rdy,
                                input logic [1:0] pcw, input logic rv, input logic [63:0] addr,
                                input logic iv, input logic [31:0] ins, input logic [63:0] ipc,
                                input logic mis);
        vec_t r;
        r.rst = rst; r.pc = p; r.fl = fl; r.ok = ok; r.data = d; r.rdy = rdy;
        r.pcw = pcw; r.rv = rv; r.addr = addr;
        r.iv = iv; r.ins = ins; r.ipc = ipc; r.mis = mis;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
    endtask

    task automatic drive(input logic rst, input logic [63:0] p, input logic fl,
                         input logic ok, input logic [31:0] d, input logic rdy);
        reset = rst; pc = p; flush = fl; iresp_data_ok = ok; iresp_data = d; dec_ready = rdy;
    endtask

    // Drive one record, check combinational outputs, clock it, check registered outputs.
    task automatic apply(input vec_t v, input int idx);
        drive(v.rst, v.pc, v.fl, v.ok, v.data, v.rdy);
        #1;
        chk("PCWrite", idx, 64'(PCWrite), 64'(v.pcw));
        chk("ireq_valid", idx, 64'(ireq_valid), 64'(v.rv));
        if (v.rv) chk("ireq_addr", idx, ireq_addr, v.addr);
        @(posedge clk);
        #1;
        chk("inst_valid", idx, 64'(inst_valid), 64'(v.iv));
        if (v.iv || !v.rst) begin
            chk("inst", idx, 64'(inst), 64'(v.ins));
            chk("inst_pc", idx, inst_pc, v.ipc);
            chk("inst_misalign", idx, 64'(inst_misalign), 64'(v.mis));
        end
    endtask

    localparam logic [63:0] B = 64'h8000_0000;

    initial begin
        drive(1'b0, B, 1'b0, 1'b0, 32'h0, 1'b1);

        //           rst pc          fl ok data          rdy pcw    rv addr        iv ins           ipc         mis
        tv.push_back(mk(0, B,          0, 0, 32'h0,        1, 2'b01, 0, 64'h0,       0, 32'h0,        64'h0,       0)); // reset
        // zero-wait stream
        tv.push_back(mk(1, B,          0, 1, 32'h00000013, 1, 2'b00, 1, B,           1, 32'h00000013, B,           0));
        tv.push_back(mk(1, B+4,        0, 1, 32'h00100093, 1, 2'b00, 1, B+4,         1, 32'h00100093, B+4,         0));
        tv.push_back(mk(1, B+8,        0, 1, 32'h00200113, 1, 2'b00, 1, B+8,         1, 32'h00200113, B+8,         0));
        // 3-cycle latency
        tv.push_back(mk(1, B+12,       0, 0, 32'h0,        1, 2'b01, 1, B+12,        0, 32'h0,        64'h0,       0));
        tv.push_back(mk(1, B+12,       0, 0, 32'h0,        1, 2'b01, 1, B+12,        0, 32'h0,        64'h0,       0));
        tv.push_back(mk(1, B+12,       0, 1, 32'h00300193, 1, 2'b00, 1, B+12,        1, 32'h00300193, B+12,        0));
        // slot full, response arrives -> skid, HOLD
        tv.push_back(mk(1, B+16,       0, 1, 32'h00400213, 0, 2'b00, 1, B+16,        1, 32'h00300193, B+12,        0));
        tv.push_back(mk(1, B+20,       0, 0, 32'h0,        0, 2'b01, 0, 64'h0,       1, 32'h00300193, B+12,        0));
        tv.push_back(mk(1, B+20,       0, 0, 32'h0,        1, 2'b01, 0, 64'h0,       1, 32'h00400213, B+16,        0));
        tv.push_back(mk(1, B+20,       0, 1, 32'h00500293, 1, 2'b00, 1, B+20,        1, 32'h00500293, B+20,        0));
        // flush on first cycle of a 3-cycle request -> DISCARD at old address
        tv.push_back(mk(1, B+24,       1, 0, 32'h0,        1, 2'b00, 1, B+24,        0, 32'h0,        64'h0,       0));
        tv.push_back(mk(1, B+64'h1000, 0, 0, 32'h0,        1, 2'b01, 1, B+24,        0, 32'h0,        64'h0,       0));
        tv.push_back(mk(1, B+64'h1000, 0, 1, 32'hDEADBEEF, 1, 2'b01, 1, B+24,        0, 32'h0,        64'h0,       0));
        tv.push_back(mk(1, B+64'h1000, 0, 1, 32'h00600313, 1, 2'b00, 1, B+64'h1000,  1, 32'h00600313, B+64'h1000,  0));
        // flush coincident with data_ok -> dropped, no DISCARD
        tv.push_back(mk(1, B+64'h1004, 1, 1, 32'hDEADBEEF, 1, 2'b00, 1, B+64'h1004,  0, 32'h0,        64'h0,       0));
        tv.push_back(mk(1, B+64'h2000, 0, 1, 32'h00700393, 1, 2'b00, 1, B+64'h2000,  1, 32'h00700393, B+64'h2000,  0));
        // misaligned PC
        tv.push_back(mk(1, B+2,        0, 0, 32'h0,        1, 2'b00, 0, 64'h0,       1, 32'h0,        B+2,         1));
        tv.push_back(mk(1, B+6,        0, 0, 32'h0,        0, 2'b01, 0, 64'h0,       1, 32'h0,        B+2,         1));
        // repeated flushes in DISCARD, exactly one data_ok ends it
        tv.push_back(mk(1, B+8,        0, 0, 32'h0,        1, 2'b01, 1, B+8,         0, 32'h0,        64'h0,       0));
        tv.push_back(mk(1, B+8,        1, 0, 32'h0,        1, 2'b00, 1, B+8,         0, 32'h0,        64'h0,       0));
        tv.push_back(mk(1, B+64'h3000, 1, 0, 32'h0,        1, 2'b00, 1, B+8,         0, 32'h0,        64'h0,       0));
        tv.push_back(mk(1, B+64'h4000, 0, 1, 32'hDEADBEEF, 1, 2'b01, 1, B+8,         0, 32'h0,        64'h0,       0));
        tv.push_back(mk(1, B+64'h4000, 0, 1, 32'h00800413, 1, 2'b00, 1, B+64'h4000,  1, 32'h00800413, B+64'h4000,  0));
        // flush in HOLD drops both slot and skid
        tv.push_back(mk(1, B+64'h4004, 0, 1, 32'h00900493, 0, 2'b00, 1, B+64'h4004,  1, 32'h00800413, B+64'h4000,  0));
        tv.push_back(mk(1, B+64'h4008, 1, 0, 32'h0,        0, 2'b00, 0, 64'h0,       0, 32'h0,        64'h0,       0));
        tv.push_back(mk(1, B+64'h5000, 0, 1, 32'h00a00513, 1, 2'b00, 1, B+64'h5000,  1, 32'h00a00513, B+64'h5000,  0));

        @(negedge clk);
        foreach (tv[i]) apply(tv[i], i);

        // Reset asserted while in HOLD: everything back to reset values at the next edge.
        drive(1'b1, B+64'h6000, 1'b0, 1'b1, 32'h11111111, 1'b0);
        #1;
        chk("hold_entry_pcw", 100, 64'(PCWrite), 64'(2'b00));
        @(posedge clk); #1;
        chk("hold_entry_inst", 100, 64'(inst), 64'h00a00513);
        drive(1'b0, B+64'h6004, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("rst_hold_pcw", 101, 64'(PCWrite), 64'(2'b01));
        chk("rst_hold_rv", 101, 64'(ireq_valid), 64'h0);
        @(posedge clk); #1;
        chk("rst_hold_iv", 101, 64'(inst_valid), 64'h0);
        chk("rst_hold_inst", 101, 64'(inst), 64'h0);
        chk("rst_hold_ipc", 101, inst_pc, 64'h0);
        chk("rst_hold_mis", 101, 64'(inst_misalign), 64'h0);
        // Released: back in FETCH, requesting the reset PC.
        drive(1'b1, B, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("post_rst_rv", 102, 64'(ireq_valid), 64'h1);
        chk("post_rst_addr", 102, ireq_addr, B);
        chk("post_rst_pcw", 102, 64'(PCWrite), 64'(2'b01));
        @(posedge clk); #1;
        drive(1'b1, B, 1'b0, 1'b1, 32'h00000073, 1'b1);
        #1;
        chk("post_rst_load", 103, 64'(PCWrite), 64'(2'b00));
        @(posedge clk); #1;
        chk("post_rst_iv", 103, 64'(inst_valid), 64'h1);
        chk("post_rst_inst", 103, 64'(inst), 64'h00000073);
        chk("post_rst_ipc", 103, inst_pc, B);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller for the pipelined 64-bit core. It reads the architectural `pc` held by the PC register and presents it as a request on the instruction bus. It collects the returned 32-bit instruction into a registered fetch/decode slot and tells the PC register when to advance through `PCWrite`. It also discards responses that belong to a request made stale by a pipeline redirect (`flush`).

## Interface
Parameters
- none; reset PC value is `PCINIT` from `common`, owned by the PC register.

Ports
- `clk`  in  1  sole clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-low: state is reset on a posedge where `reset == 0`.
- `pc`  in  64 (`u64`)  current PC register value.
- `PCWrite`  out  2 (`u2`)  `2'b00` = PC register loads `pc_nxt` this edge; `2'b01` = hold.
- `flush`  in  1  redirect this cycle; `pc_nxt` carries the target.
- `ireq_valid`  out  1  instruction bus request valid.
- `ireq_addr`  out  64  request address.
- `iresp_data_ok`  in  1  one pulse per request; may be in the same cycle as `ireq_valid` or later.
- `iresp_data`  in  32  instruction, valid with `iresp_data_ok`.
- `inst_valid`  out  1  fetch/decode slot holds an instruction.
- `inst`  out  32  slot instruction.
- `inst_pc`  out  64  PC of slot instruction.
- `inst_misalign`  out  1  slot entry is a misaligned-fetch exception (`inst` = 0).
- `dec_ready`  in  1  decode consumes the slot this cycle when `inst_valid`.

## Operation
Bus rule
- Once `ireq_valid` is high, it stays high with `ireq_addr` stable until the cycle `iresp_data_ok` is seen.

Storage
- Output slot: `inst_valid`, `inst`, `inst_pc`, `inst_misalign`.
- One skid entry of the same shape.
- Latched address `req_addr`.

Slot free condition
- `slot_free = !inst_valid || dec_ready`.

States and behaviour
- FETCH
  - If `pc[1:0] != 0`: `ireq_valid = 0`. If `slot_free`, write the slot with `inst_misalign = 1`, `inst_pc = pc`, and set `PCWrite = 00`.
  - Otherwise: `ireq_valid = 1`, `ireq_addr = pc`, and `req_addr <= pc`.
  - On `iresp_data_ok` with no `flush`:
    - If `slot_free`: write the slot (`inst_pc = pc`), `PCWrite = 00`, stay in FETCH.
    - Else: write the skid entry, `PCWrite = 00`, go to HOLD.
- HOLD
  - `ireq_valid = 0`, `PCWrite = 01`.
  - When `dec_ready`: skid moves to the slot, go to FETCH.
- DISCARD
  - `ireq_valid = 1`, `ireq_addr = req_addr`, `PCWrite = 01`.
  - On `iresp_data_ok`: drop the data, go to FETCH.
- Without a flush, `PCWrite = 01` in every case not listed above.

Flush (overrides everything else in the same cycle)
- `PCWrite = 00` so the redirect target loads.
- Slot and skid are invalidated at the edge.
- Next state:
  - DISCARD if a request was presented this cycle and `iresp_data_ok = 0`.
  - Otherwise FETCH; this covers a same-cycle response, which is dropped.
- A flush in DISCARD stays in DISCARD.
- A flush in HOLD goes to FETCH.

Slot consumption
- Slot consumed with no new write and no skid move: `inst_valid` falls.

## Timing
Reset (`reset == 0` at a posedge)
- State = FETCH.
- `inst_valid = 0`, `inst = 0`, `inst_pc = 0`, `inst_misalign = 0`, skid empty.
- While `reset == 0`: `ireq_valid = 0` and `PCWrite = 01` (combinational override).
- First request is issued in the first cycle after release, using the PC register's reset value.
- Reset mid-request abandons it; the bus is reset in the same cycle.

Latency and throughput
- `iresp_data_ok` in cycle t → `inst_valid`/`inst` visible in t+1.
- Sustained throughput is 1 instruction/cycle when the bus answers in the same cycle and `dec_ready = 1`.
- `PCWrite` and `ireq_*` are combinational from state and inputs; all slot outputs are registered.

Boundary conditions
- HOLD is reached only with the slot full; the skid never overflows because no request is issued in HOLD.
- DISCARD lasts until exactly one `iresp_data_ok`, regardless of how many flushes occur meanwhile.

## Test plan
- Zero-wait bus (`iresp_data_ok` same cycle), `dec_ready = 1`, pc = 0x8000_0000, 0x8000_0004, … → `inst_valid` continuous from cycle 2, `inst_pc` increments by 4, `PCWrite = 00` every cycle.
- 3-cycle bus latency → `ireq_addr` stable for 3 cycles, `PCWrite = 01` for 2 cycles then `00`, `inst_valid` the cycle after `data_ok`.
- `dec_ready = 0` with the slot full and a new response arriving → skid fills, HOLD, `ireq_valid = 0`. After `dec_ready` rises, both instructions are delivered in order, then FETCH resumes.
- `flush` on the 1st cycle of a 3-cycle request → `PCWrite = 00` once, DISCARD for 2 cycles at the old address. The stale `iresp_data` (0xDEADBEEF) never appears on `inst`; the next request uses the redirect target.
- `flush` coincident with `iresp_data_ok` → data dropped, `inst_valid = 0` next cycle, no DISCARD entered. `reset` driven to 0 mid-HOLD → all outputs return to reset values at the next edge.
- pc = 0x8000_0002 → no bus request; slot gets `inst_misalign = 1`, `inst_pc = 0x8000_0002`, `PCWrite = 00`.
